pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined ARM datapath (F/D/E/M/W).
- Generates E-stage operand forwarding selects.
- Generates stall and flush controls for the pipeline registers, covering load-use, PC-write (PCSrc) drain, taken branch and data-memory wait states.
- A small FSM tracks multi-cycle memory accesses. On a wait-state timeout it halts the pipeline.

Parameters:
MEM_TIMEOUT, 16, max consecutive memory-wait cycles before HALT; 0 = timeout disabled
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
RA1D  in  4  source reg 1 of instruction in D
RA2D  in  4  source reg 2 of instruction in D
RA1E  in  4  source reg 1 of instruction in E
RA2E  in  4  source reg 2 of instruction in E
RdE  in  4  dest reg in E
RdM  in  4  dest reg in M
RdW  in  4  dest reg in W
MemtoRegE  in  1  instruction in E is a load
RegWriteM  in  1  M writes register file
RegWriteW  in  1  W writes register file
PCSrcD  in  1  D writes PC (R15)
PCSrcE  in  1  E writes PC (R15)
PCSrcM  in  1  M writes PC (R15)
PCSrcW  in  1  W writes PC (R15)
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  load/store active in M
MemReadyM  in  1  data memory completes access this cycle
forwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
forwardBE  out  2  SrcB select, same encoding as forwardAE
StallF  out  1  hold PC register
StallD  out  1  hold D register
StallE  out  1  hold E register
StallM  out  1  hold M register
FlushD  out  1  clear D register
FlushE  out  1  clear E register
FlushW  out  1  clear W register (bubble)
halted  out  1  sticky: memory timeout occurred
stall_cycles  out  CNT_W  optional perf counter
flush_cycles  out  CNT_W  optional perf counter

Behaviour:
- Forwarding (combinational):
  - forwardAE=10 if RegWriteM && RdM==RA1E.
  - Else forwardAE=01 if RegWriteW && RdW==RA1E.
  - Else forwardAE=00.
  - forwardBE follows the same rules on RA2E.
  - Source R15 (4'hF) never forwards; select is 00.
- Internal terms:
  - LdStall = MemtoRegE && (RdE==RA1D || RdE==RA2D)
  - PCWrPend = PCSrcD|PCSrcE|PCSrcM
  - MemStall = MemReqM && !MemReadyM
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN; wait_cnt=0.
  - RUN: if MemStall, go to MEM_WAIT and set wait_cnt=1. MemReqM with MemReadyM in the same cycle causes no stall and no transition.
  - MEM_WAIT, MemReadyM=1: go to RUN, wait_cnt=0. Stalls drop combinationally in that same cycle.
  - MEM_WAIT, MemStall, wait_cnt==MEM_TIMEOUT (MEM_TIMEOUT>0): go to HALT. Else wait_cnt+1, stay in MEM_WAIT.
  - HALT: terminal until reset.
- Output priority, highest first:
  1. HALT or MemStall (freeze):
     - StallF=StallD=StallE=StallM=1 and FlushW=1.
     - FlushD=FlushE=0, even with LdStall/BranchTakenE.
     - A held branch is re-evaluated after the freeze releases.
  2. Normal:
     - StallF = LdStall|PCWrPend
     - StallD = LdStall
     - StallE = StallM = 0
     - FlushD = PCWrPend|PCSrcW|BranchTakenE
     - FlushE = LdStall|BranchTakenE
     - FlushW = 0
- halted=1 only in HALT.
- While reset is low:
  - All Stall outputs = 0.
  - FlushD = FlushE = FlushW = 1.
  - forward selects = 00.
  - halted = 0.
  - Perf counters = 0.
- Reset mid-wait: returns to RUN immediately (asynchronous). No residual stall after reset is released.
- All state is updated on the clk rising edge only.

Optional Feature:
HAZ_PERF_EN
- Defined:
  - stall_cycles increments each cycle StallF=1 (reset low excluded).
  - flush_cycles increments each cycle FlushD|FlushE|FlushW=1 (reset low excluded).
  - Both counters saturate at all-ones.
- Undefined: both outputs tied to 0; no counter flops.

Test Plan:
- Forwarding: RA1E=3, RdM=3, RegWriteM=1, RdW=3, RegWriteW=1 -> forwardAE=10. Drop RegWriteM -> 01. RA1E=15 -> 00.
- Load-use: MemtoRegE=1, RdE=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0 for exactly 1 cycle once E advances.
- PC write: PCSrcD=1 pulse propagating D->E->M->W -> StallF=1 for 3 cycles; FlushD=1 for 4 cycles.
- Memory wait: MemReqM=1 with MemReadyM low 3 cycles, then high -> StallF..StallM=1 and FlushW=1 for 3 cycles, 0 in the ready cycle. Branch taken in E during the wait -> no FlushE until the wait ends.
- Timeout: MEM_TIMEOUT=4, MemReadyM held low -> HALT entered after 5 wait cycles; halted=1 sticky; stalls stay 1. Async reset low -> halted=0 and state RUN before the next clk edge.
- HAZ_PERF_EN: 1 load-use stall + 1 taken branch -> stall_cycles=1, flush_cycles=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       RA1E;
  logic [3:0]       RA2E;
  logic [3:0]       RdE;
  logic [3:0]       RdM;
  logic [3:0]       RdW;
  logic             MemtoRegE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             PCSrcD;
  logic             PCSrcE;
  logic             PCSrcM;
  logic             PCSrcW;
  logic             BranchTakenE;
  logic             MemReqM;
  logic             MemReadyM;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, RdE, RdM, RdW,
    output MemtoRegE, RegWriteM, RegWriteW,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    input  forwardAE, forwardBE,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, RdE, RdM, RdW,
    input  MemtoRegE, RegWriteM, RegWriteW,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    output forwardAE, forwardBE,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, halted,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the F/D/E/M/W ARM pipeline: forwarding, stall/flush, memory-wait FSM.
// Define HAZ_PERF_EN to build the saturating stall_cycles/flush_cycles counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WC_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_cnt_nxt;
  logic            w_ld_stall;
  logic            w_pc_wr_pend;
  logic            w_mem_stall;
  logic            w_freeze;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic            w_stall_f;
  logic            w_stall_d;
  logic            w_stall_e;
  logic            w_stall_m;
  logic            w_flush_d;
  logic            w_flush_e;
  logic            w_flush_w;
  logic            w_halted;

  // R15 reads the PC path, never a forwarded result; M wins over W as the younger producer.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic       wr_m,
                                         input logic [3:0] rd_m,
                                         input logic       wr_w,
                                         input logic [3:0] rd_w);
    logic [1:0] sel;
    if (src == 4'hF) begin
      sel = 2'b00;
    end else if (wr_m && (rd_m == src)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_ld_stall   = bus.MemtoRegE && ((bus.RdE == bus.RA1D) || (bus.RdE == bus.RA2D));
  assign w_pc_wr_pend = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;
  assign w_mem_stall  = bus.MemReqM && !bus.MemReadyM;
  assign w_freeze     = (r_state == ST_HALT) || w_mem_stall;

  // Memory-wait FSM state and wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= {WC_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Next-state logic; the wait counter saturates so a disabled timeout never wraps into a match.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end else begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = {WC_W{1'b0}};
        end
      end
      ST_MEM_WAIT: begin
        if (bus.MemReadyM) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = {WC_W{1'b0}};
        end else if (w_mem_stall && (MEM_TIMEOUT > 0) && (r_wait_cnt == WC_W'(MEM_TIMEOUT))) begin
          w_state_nxt    = ST_HALT;
          w_wait_cnt_nxt = r_wait_cnt;
        end else if (r_wait_cnt == {WC_W{1'b1}}) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = r_wait_cnt;
        end else begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      ST_HALT: begin
        w_state_nxt    = ST_HALT;
        w_wait_cnt_nxt = r_wait_cnt;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = {WC_W{1'b0}};
      end
    endcase
  end

  // Pipeline controls: reset forces bubbles, a freeze holds everything and only bubbles W.
  always_comb begin
    w_fwd_a   = 2'b00;
    w_fwd_b   = 2'b00;
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_halted  = 1'b0;
    if (!rst_n) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_freeze) begin
      w_fwd_a   = fwd_sel(bus.RA1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      w_fwd_b   = fwd_sel(bus.RA2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
      w_halted  = (r_state == ST_HALT);
    end else begin
      w_fwd_a   = fwd_sel(bus.RA1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      w_fwd_b   = fwd_sel(bus.RA2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      w_stall_f = w_ld_stall | w_pc_wr_pend;
      w_stall_d = w_ld_stall;
      w_flush_d = w_pc_wr_pend | bus.PCSrcW | bus.BranchTakenE;
      w_flush_e = w_ld_stall | bus.BranchTakenE;
    end
  end

  assign bus.forwardAE = w_fwd_a;
  assign bus.forwardBE = w_fwd_b;
  assign bus.StallF    = w_stall_f;
  assign bus.StallD    = w_stall_d;
  assign bus.StallE    = w_stall_e;
  assign bus.StallM    = w_stall_m;
  assign bus.FlushD    = w_flush_d;
  assign bus.FlushE    = w_flush_e;
  assign bus.FlushW    = w_flush_w;
  assign bus.halted    = w_halted;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_cycles;

  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_flush_cycles <= {CNT_W{1'b0}};
    end else begin
      if (w_stall_f && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if ((w_flush_d | w_flush_e | w_flush_w) && (r_flush_cycles != {CNT_W{1'b1}})) begin
        r_flush_cycles <= r_flush_cycles + CNT_W'(1);
      end else begin
        r_flush_cycles <= r_flush_cycles;
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_cycles = r_flush_cycles;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); perf expectations follow HAZ_PERF_EN.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 32;

`ifdef HAZ_PERF_EN
  localparam logic [31:0] EXP_STALL_CNT = 32'd1;
  localparam logic [31:0] EXP_FLUSH_CNT = 32'd2;
`else
  localparam logic [31:0] EXP_STALL_CNT = 32'd0;
  localparam logic [31:0] EXP_FLUSH_CNT = 32'd0;
`endif

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] stl;
    logic [2:0] fls;
    logic       hlt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] stl, input logic [2:0] fls, input logic hlt);
    exp_t e;
    e.fa  = fa;
    e.fb  = fb;
    e.stl = stl;
    e.fls = fls;
    e.hlt = hlt;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.RA1D = 4'd0; bus.RA2D = 4'd0; bus.RA1E = 4'd0; bus.RA2E = 4'd0;
    bus.RdE = 4'd0; bus.RdM = 4'd0; bus.RdW = 4'd0;
    bus.MemtoRegE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.PCSrcD = 1'b0; bus.PCSrcE = 1'b0; bus.PCSrcM = 1'b0; bus.PCSrcW = 1'b0;
    bus.BranchTakenE = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  // Push the expectation, sample mid-cycle, then let the rising edge commit the step.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    cmp({tag, ".fwdA"},  32'(bus.forwardAE), 32'(x.fa));
    cmp({tag, ".fwdB"},  32'(bus.forwardBE), 32'(x.fb));
    cmp({tag, ".stall"}, 32'({bus.StallF, bus.StallD, bus.StallE, bus.StallM}), 32'(x.stl));
    cmp({tag, ".flush"}, 32'({bus.FlushD, bus.FlushE, bus.FlushW}), 32'(x.fls));
    cmp({tag, ".halt"},  32'(bus.halted), 32'(x.hlt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    bus.RA1E = 4'd3; bus.RdM = 4'd3; bus.RegWriteM = 1'b1;
    bus.MemtoRegE = 1'b1; bus.RdE = 4'd5; bus.RA2D = 4'd5; bus.PCSrcD = 1'b1;
    step("rst", mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0));
    rst_n = 1'b1;
    idle();
    step("idle0", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    bus.RA1E = 4'd3; bus.RA2E = 4'd3; bus.RdM = 4'd3; bus.RegWriteM = 1'b1;
    bus.RdW = 4'd3; bus.RegWriteW = 1'b1;
    step("fwd_m", mk(2'b10, 2'b10, 4'b0000, 3'b000, 1'b0));
    bus.RegWriteM = 1'b0;
    step("fwd_w", mk(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0));
    bus.RA1E = 4'd15; bus.RA2E = 4'd15; bus.RdM = 4'd15; bus.RdW = 4'd15;
    bus.RegWriteM = 1'b1;
    step("fwd_r15", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    bus.RA1E = 4'd4; bus.RdM = 4'd4; bus.RA2E = 4'd9; bus.RdW = 4'd9;
    step("fwd_mix", mk(2'b10, 2'b01, 4'b0000, 3'b000, 1'b0));

    idle();
    bus.MemtoRegE = 1'b1; bus.RdE = 4'd5; bus.RA2D = 4'd5;
    step("lu_b", mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    idle();
    step("lu_adv", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    bus.MemtoRegE = 1'b1; bus.RdE = 4'd5; bus.RA1D = 4'd5;
    step("lu_a", mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    bus.MemtoRegE = 1'b0;
    step("lu_noload", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    idle(); bus.PCSrcD = 1'b1;
    step("pc_d", mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    idle(); bus.PCSrcE = 1'b1;
    step("pc_e", mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    idle(); bus.PCSrcM = 1'b1;
    step("pc_m", mk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    idle(); bus.PCSrcW = 1'b1;
    step("pc_w", mk(2'b00, 2'b00, 4'b0000, 3'b100, 1'b0));
    idle();
    step("pc_done", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    bus.BranchTakenE = 1'b1;
    step("br", mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0));
    idle(); bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
    step("mem_fast", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    bus.MemReadyM = 1'b0; bus.BranchTakenE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("mw%0d", i), mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    end
    bus.MemReadyM = 1'b1;
    step("mw_rdy", mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0));
    idle();
    step("mw_after", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    bus.MemReqM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("to%0d", i), mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    end
    idle(); bus.MemReadyM = 1'b1; bus.BranchTakenE = 1'b1;
    bus.MemtoRegE = 1'b1; bus.RdE = 4'd5; bus.RA1D = 4'd5;
    step("halt1", mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
    idle();
    step("halt2", mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));

    rst_n = 1'b0;
    step("areset", mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0));
    rst_n = 1'b1;
    step("post_rst", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    bus.MemtoRegE = 1'b1; bus.RdE = 4'd7; bus.RA2D = 4'd7;
    step("perf_lu", mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    idle(); bus.BranchTakenE = 1'b1;
    step("perf_br", mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0));
    idle();
    step("perf_idle", mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    cmp("perf.stall_cycles", bus.stall_cycles, EXP_STALL_CNT);
    cmp("perf.flush_cycles", bus.flush_cycles, EXP_FLUSH_CNT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
